decode_ctrl_stage: RTL and testbench

- Registered RV32I decode/control stage that replaces the purely combinational control ROM.
- Sits between the fetch and execute pipeline stages, with a valid/ready handshake on both sides.
- Decodes the instruction into control fields, passes PC and register indices through, and flags illegal encodings.
- Inserts load-use bubbles (configurable count) and accepts a synchronous flush from branch resolution.

---
 rtl/decode_ctrl_stage.sv | 246 ++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// RV32I decode/control stage: registered control word, load-use bubbles, flush. Latency 1 cycle.
// Backpressure: holds its output while out_valid & !out_ready. Optional mul/div decode: RV32M_EN.
module decode_ctrl_stage #(
    parameter int XLEN             = 32,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [3:0]      out_aluop,
    output logic [1:0]      out_alumux1_sel,
    output logic [2:0]      out_alumux2_sel,
    output logic [2:0]      out_regfilemux_sel,
    output logic [1:0]      out_pcmux_sel,
    output logic [2:0]      out_cmp_op,
    output logic            out_cmpmux_sel,
    output logic            out_load_regfile,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_illegal
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef struct packed {
        logic [3:0] aluop;
        logic [1:0] mux1;
        logic [2:0] mux2;
        logic [2:0] rfmux;
        logic [1:0] pcmux;
        logic [2:0] cmp_op;
        logic       cmpmux;
        logic       ld_rf;
        logic       mem_rd;
        logic       mem_wr;
        logic       illegal;
    } ctrl_t;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    ctrl_t raw, dec, ctl_q;
    logic  bad, raw_rs1, raw_rs2, use_rs1, use_rs2;

    always_comb begin
        raw     = '0;
        bad     = 1'b0;
        raw_rs1 = 1'b0;
        raw_rs2 = 1'b0;
        case (opcode)
            OP_LUI: begin
                raw.mux1  = 2'd2;
                raw.mux2  = 3'd1;
                raw.rfmux = 3'd2;
                raw.ld_rf = 1'b1;
            end
            OP_AUIPC: begin
                raw.mux1  = 2'd1;
                raw.mux2  = 3'd1;
                raw.ld_rf = 1'b1;
            end
            OP_JAL: begin
                raw.mux1  = 2'd1;
                raw.mux2  = 3'd5;
                raw.rfmux = 3'd4;
                raw.pcmux = 2'd2;
                raw.ld_rf = 1'b1;
            end
            OP_JALR: begin
                bad       = (funct3 != 3'd0);
                raw.rfmux = 3'd4;
                raw.pcmux = 2'd3;
                raw.ld_rf = 1'b1;
                raw_rs1   = 1'b1;
            end
            OP_BR: begin
                bad        = (funct3[2:1] == 2'b01);
                raw.mux1   = 2'd1;
                raw.mux2   = 3'd2;
                raw.pcmux  = 2'd1;
                raw.cmp_op = funct3;
                raw_rs1    = 1'b1;
                raw_rs2    = 1'b1;
            end
            OP_LOAD: begin
                // legal widths: lb, lh, lw, lbu, lhu
                bad        = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
                raw.rfmux  = 3'd3;
                raw.ld_rf  = 1'b1;
                raw.mem_rd = 1'b1;
                raw_rs1    = 1'b1;
            end
            OP_STORE: begin
                bad        = funct3[2] || (funct3[1:0] == 2'b11);
                raw.mux2   = 3'd3;
                raw.mem_wr = 1'b1;
                raw_rs1    = 1'b1;
                raw_rs2    = 1'b1;
            end
            OP_IMM: begin
                raw.ld_rf = 1'b1;
                raw_rs1   = 1'b1;
                case (funct3)
                    3'd2, 3'd3: begin
                        // slt/sltu reuse the branch comparator as blt/bltu
                        raw.rfmux  = 3'd1;
                        raw.cmpmux = 1'b1;
                        raw.cmp_op = {1'b1, funct3[0], 1'b0};
                    end
                    3'd1: begin
                        raw.aluop = 4'd1;
                        bad       = (funct7 != 7'd0);
                    end
                    3'd5: begin
                        raw.aluop = funct7[5] ? 4'd2 : 4'd5;
                        bad       = ({funct7[6], funct7[4:0]} != 6'd0);
                    end
                    default: raw.aluop = {1'b0, funct3};
                endcase
            end
            OP_REG: begin
                raw.mux2  = 3'd4;
                raw.ld_rf = 1'b1;
                raw_rs1   = 1'b1;
                raw_rs2   = 1'b1;
                case (funct7)
                    7'h00: begin
                        if (funct3[2:1] == 2'b01) begin
                            raw.rfmux  = 3'd1;
                            raw.cmp_op = {1'b1, funct3[0], 1'b0};
                        end else begin
                            raw.aluop = {1'b0, funct3};
                        end
                    end
                    7'h20: begin
                        case (funct3)
                            3'd0:    raw.aluop = 4'd3;
                            3'd5:    raw.aluop = 4'd2;
                            default: bad = 1'b1;
                        endcase
                    end
                    7'h01: begin
`ifdef RV32M_EN
                        raw.aluop = {1'b1, funct3};
`else
                        bad = 1'b1;
`endif
                    end
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase

        dec     = raw;
        use_rs1 = raw_rs1;
        use_rs2 = raw_rs2;
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end
    end

    logic [2:0] ld_cnt;
    logic [4:0] ld_rd;
    logic       adv, hazard, accept;

    assign adv      = !out_valid || out_ready;
    assign hazard   = in_valid && (ld_cnt != 3'd0) &&
                      ((use_rs1 && (rs1 == ld_rd)) || (use_rs2 && (rs2 == ld_rd)));
    assign in_ready = rst_n && adv && !flush && !hazard;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
            out_rd    <= '0;
            ctl_q     <= '0;
            ld_cnt    <= '0;
            ld_rd     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ld_cnt    <= '0;
        end else if (adv) begin
            // a hazard or empty input leaves a bubble; fields keep their last value
            out_valid <= accept;
            if (accept) begin
                out_pc  <= in_pc;
                out_rs1 <= use_rs1 ? rs1 : 5'd0;
                out_rs2 <= use_rs2 ? rs2 : 5'd0;
                out_rd  <= dec.ld_rf ? rd : 5'd0;
                ctl_q   <= dec;
            end
            if (accept && dec.mem_rd && (rd != 5'd0)) begin
                ld_cnt <= 3'(LOAD_USE_BUBBLES);
                ld_rd  <= rd;
            end else if (ld_cnt != 3'd0) begin
                ld_cnt <= ld_cnt - 3'd1;
            end
        end
    end

    assign out_aluop          = ctl_q.aluop;
    assign out_alumux1_sel    = ctl_q.mux1;
    assign out_alumux2_sel    = ctl_q.mux2;
    assign out_regfilemux_sel = ctl_q.rfmux;
    assign out_pcmux_sel      = ctl_q.pcmux;
    assign out_cmp_op         = ctl_q.cmp_op;
    assign out_cmpmux_sel     = ctl_q.cmpmux;
    assign out_load_regfile   = ctl_q.ld_rf;
    assign out_mem_read       = ctl_q.mem_rd;
    assign out_mem_write      = ctl_q.mem_wr;
    assign out_illegal        = ctl_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Randomized scoreboard bench for decode_ctrl_stage against a mnemonic-level reference model.
module tb_decode_ctrl_stage;

    localparam int LUB = 2;
`ifdef RV32M_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0, out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [3:0]  out_aluop;
    logic [1:0]  out_alumux1_sel, out_pcmux_sel;
    logic [2:0]  out_alumux2_sel, out_regfilemux_sel, out_cmp_op;
    logic        out_cmpmux_sel, out_load_regfile, out_mem_read, out_mem_write, out_illegal;

    decode_ctrl_stage #(.XLEN(32), .LOAD_USE_BUBBLES(LUB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_aluop(out_aluop), .out_alumux1_sel(out_alumux1_sel),
        .out_alumux2_sel(out_alumux2_sel), .out_regfilemux_sel(out_regfilemux_sel),
        .out_pcmux_sel(out_pcmux_sel), .out_cmp_op(out_cmp_op), .out_cmpmux_sel(out_cmpmux_sel),
        .out_load_regfile(out_load_regfile), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  aluop;
        logic [1:0]  m1;
        logic [2:0]  m2, rfm;
        logic [1:0]  pcm;
        logic [2:0]  cmp;
        logic        cmpm, ldrf, mr, mw, ill;
    } exp_t;

    typedef enum {K_ILL, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST,
                  K_ALUI, K_SLTI, K_ALUR, K_SLTR, K_MD} kind_e;

    exp_t sb[$];
    int   n_vec = 0, n_err = 0;
    bit   m_ov = 1'b0, last_acc = 1'b0;
    int   m_stall = 0;
    logic [4:0] m_ldrd = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Classify by mnemonic, then fill the control word from a per-mnemonic table.
    function automatic void ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                       output exp_t e, output bit u1, output bit u2);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        kind_e k = K_ILL;
        logic [3:0] alu = 4'd0;
        case (op)
            7'h37: k = K_LUI;
            7'h17: k = K_AUIPC;
            7'h6F: k = K_JAL;
            7'h67: if (f3 == 3'd0) k = K_JALR;
            7'h63: if (f3 != 3'd2 && f3 != 3'd3) k = K_BR;
            7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) k = K_LD;
            7'h23: if (f3 <= 3'd2) k = K_ST;
            7'h13: begin
                if (f3 == 3'd2 || f3 == 3'd3) k = K_SLTI;
                else if (f3 == 3'd1) begin if (f7 == 7'h00) begin k = K_ALUI; alu = 4'd1; end end
                else if (f3 == 3'd5) begin
                    if (f7 == 7'h00) begin k = K_ALUI; alu = 4'd5; end
                    else if (f7 == 7'h20) begin k = K_ALUI; alu = 4'd2; end
                end else begin k = K_ALUI; alu = {1'b0, f3}; end
            end
            7'h33: begin
                if (f7 == 7'h01) begin if (MD_EN) k = K_MD; end
                else if (f7 == 7'h00) begin
                    if (f3 == 3'd2 || f3 == 3'd3) k = K_SLTR;
                    else begin k = K_ALUR; alu = {1'b0, f3}; end
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'd0) begin k = K_ALUR; alu = 4'd3; end
                    if (f3 == 3'd5) begin k = K_ALUR; alu = 4'd2; end
                end
            end
            default: k = K_ILL;
        endcase
        e = '0;
        e.pc = pc;
        u1 = 1'b0;
        u2 = 1'b0;
        case (k)
            K_LUI:   begin e.m1 = 2'd2; e.m2 = 3'd1; e.rfm = 3'd2; e.ldrf = 1'b1; end
            K_AUIPC: begin e.m1 = 2'd1; e.m2 = 3'd1; e.ldrf = 1'b1; end
            K_JAL:   begin e.m1 = 2'd1; e.m2 = 3'd5; e.rfm = 3'd4; e.pcm = 2'd2; e.ldrf = 1'b1; end
            K_JALR:  begin e.rfm = 3'd4; e.pcm = 2'd3; e.ldrf = 1'b1; u1 = 1'b1; end
            K_BR:    begin e.m1 = 2'd1; e.m2 = 3'd2; e.pcm = 2'd1; e.cmp = f3; u1 = 1'b1; u2 = 1'b1; end
            K_LD:    begin e.rfm = 3'd3; e.mr = 1'b1; e.ldrf = 1'b1; u1 = 1'b1; end
            K_ST:    begin e.m2 = 3'd3; e.mw = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            K_ALUI:  begin e.aluop = alu; e.ldrf = 1'b1; u1 = 1'b1; end
            K_SLTI:  begin e.rfm = 3'd1; e.cmpm = 1'b1; e.cmp = (f3 == 3'd3) ? 3'd6 : 3'd4;
                           e.ldrf = 1'b1; u1 = 1'b1; end
            K_ALUR:  begin e.aluop = alu; e.m2 = 3'd4; e.ldrf = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            K_SLTR:  begin e.m2 = 3'd4; e.rfm = 3'd1; e.cmp = (f3 == 3'd3) ? 3'd6 : 3'd4;
                           e.ldrf = 1'b1; u1 = 1'b1; u2 = 1'b1; end
            K_MD:    begin e.aluop = 4'd8 + {1'b0, f3}; e.m2 = 3'd4; e.ldrf = 1'b1;
                           u1 = 1'b1; u2 = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        if (u1) e.rs1 = w[19:15];
        if (u2) e.rs2 = w[24:20];
        if (e.ldrf) e.rd = w[11:7];
    endfunction

    task automatic cycle(input bit v, input logic [31:0] w, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        exp_t e;
        bit   u1, u2, adv, haz, rdy, acc;
        @(negedge clk);
        in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
        ref_decode(w, pc, e, u1, u2);
        adv = !m_ov || ordy;
        haz = v && (m_stall != 0) && ((u1 && w[19:15] == m_ldrd) || (u2 && w[24:20] == m_ldrd));
        rdy = adv && !fl && !haz;
        #1;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, m_ov);
        acc = 1'b0;
        if (fl) begin
            sb.delete();
            m_ov = 1'b0;
            m_stall = 0;
        end else if (adv) begin
            acc = v && !haz;
            m_ov = acc;
            if (acc) sb.push_back(e);
            if (acc && e.mr && e.rd != 5'd0) begin
                m_stall = LUB;
                m_ldrd = e.rd;
            end else if (m_stall > 0) begin
                m_stall--;
            end
        end
        last_acc = acc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_fields", {out_pc, out_rd, out_aluop, out_load_regfile, out_illegal, out_mem_read}, '0);
        sb.delete();
        m_ov = 1'b0; m_stall = 0; m_ldrd = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic hold_until_accepted(input logic [31:0] w, input logic [31:0] pc, output int k);
        k = 0;
        do begin
            cycle(1'b1, w, pc, 1'b1, 1'b0);
            k++;
        end while (!last_acc && k < 12);
        chk("accept_bound", last_acc, 1'b1);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [0:8];
        logic [6:0] op, f7;
        int         sel;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        sel = $urandom_range(0, 10);
        op  = (sel > 8) ? 7'($urandom) : ops[sel];
        case ($urandom_range(0, 4))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                5'($urandom_range(0, 7)), op};
    endfunction

    // Monitor: compare whatever the DUT presents against the oldest outstanding word.
    initial begin
        exp_t act;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid && !flush) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_output: got pc %h, required no output", out_pc);
                end else begin
                    act = '{pc: out_pc, rs1: out_rs1, rs2: out_rs2, rd: out_rd, aluop: out_aluop,
                            m1: out_alumux1_sel, m2: out_alumux2_sel, rfm: out_regfilemux_sel,
                            pcm: out_pcmux_sel, cmp: out_cmp_op, cmpm: out_cmpmux_sel,
                            ldrf: out_load_regfile, mr: out_mem_read, mw: out_mem_write,
                            ill: out_illegal};
                    chk("ctrl_word", act, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int k;
        #2;
        chk("init_in_ready", in_ready, 1'b0);
        chk("init_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b1, 32'h00100393, 32'h100, 1'b1, 1'b0);        // addi x7,x0,1
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'h0000A283, 32'h104, 1'b1, 1'b0);        // lw x5,0(x1)
        hold_until_accepted(32'h00228333, 32'h108, k);         // add x6,x5,x2
        chk("load_use_bubbles", k - 1, LUB);

        cycle(1'b1, 32'h402081B3, 32'h10C, 1'b1, 1'b0);        // sub x3,x1,x2
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h00100393, 32'h110, 1'b0, 1'b0);
        cycle(1'b1, 32'h00100393, 32'h110, 1'b1, 1'b0);
        chk("accept_after_hold", last_acc, 1'b1);

        cycle(1'b1, 32'h0000A283, 32'h114, 1'b1, 1'b0);
        cycle(1'b1, 32'h00228333, 32'h118, 1'b0, 1'b1);        // flush while held
        cycle(1'b1, 32'h00228333, 32'h118, 1'b1, 1'b0);
        chk("flush_clears_hazard", last_acc, 1'b1);

        cycle(1'b1, 32'h022081B3, 32'h11C, 1'b1, 1'b0);        // mul x3,x1,x2
        cycle(1'b1, 32'h0000007F, 32'h120, 1'b1, 1'b0);        // unknown opcode
        cycle(1'b1, 32'h0020A063, 32'h124, 1'b1, 1'b0);        // branch funct3=2
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'h0000A283, 32'h128, 1'b1, 1'b0);
        cycle(1'b1, 32'h00100393, 32'h12C, 1'b0, 1'b0);
        do_reset();                                            // reset mid-handshake

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 3) != 0, rnd_instr(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
